// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters; define BRANCH_PRED_DYNAMIC_EN for the dynamic predictor, else static not-taken.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_pc_f,
  input  logic        upd_valid_e2,
  input  logic [31:0] upd_pc_e2,
  input  logic        upd_taken_e2,
  input  logic [31:0] upd_target_e2,
  input  logic        upd_is_jump_e2
);
`ifdef BRANCH_PRED_DYNAMIC_EN
  localparam int N = 1 << INDEX_BITS;
  logic [N-1:0]          valid_q;
  logic [N-1:0]          jump_q;
  logic [1:0]            ctr_q [N];
  logic [TAG_BITS-1:0]   tag_q [N];
  logic [31:0]           target_q [N];
  logic [INDEX_BITS-1:0] idx_f, idx_u;
  logic [TAG_BITS-1:0]   tag_f, tag_u;
  logic                  hit_u, wr_u;
  logic [1:0]            ctr_u, ctr_d;
  logic                  unused;
  assign unused = ^upd_pc_e2[1:0];
  always_comb begin
    idx_f = pc_f[INDEX_BITS+1:2];
    tag_f = pc_f[31:INDEX_BITS+2];
    pred_taken_f = valid_q[idx_f] && tag_q[idx_f] == tag_f && (ctr_q[idx_f][1] || jump_q[idx_f]);
    pred_pc_f = pred_taken_f ? target_q[idx_f] : pc_f + 32'd4;
  end
  always_comb begin
    idx_u = upd_pc_e2[INDEX_BITS+1:2];
    tag_u = upd_pc_e2[31:INDEX_BITS+2];
    hit_u = valid_q[idx_u] && tag_q[idx_u] == tag_u;
    ctr_u = ctr_q[idx_u];
    // a miss only reaches the write path when taken, so it allocates weakly-taken
    ctr_d = !hit_u ? 2'b10 :
            upd_taken_e2 ? (ctr_u == 2'b11 ? 2'b11 : ctr_u + 2'd1) :
            (ctr_u == 2'b00 ? 2'b00 : ctr_u - 2'd1);
    wr_u = upd_valid_e2 && (hit_u || upd_taken_e2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) ctr_q[i] <= 2'b01;
    end else if (wr_u) begin
      valid_q[idx_u] <= 1'b1;
      tag_q[idx_u] <= tag_u;
      ctr_q[idx_u] <= ctr_d;
      jump_q[idx_u] <= upd_is_jump_e2;
      if (upd_taken_e2) target_q[idx_u] <= upd_target_e2;
    end
  end
`else
  logic unused;
  assign unused = ^{clk, rst, upd_valid_e2, upd_pc_e2, upd_taken_e2, upd_target_e2, upd_is_jump_e2};
  assign pred_taken_f = 1'b0;
  assign pred_pc_f = pc_f + 32'd4;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven scoreboard bench; expectations follow BRANCH_PRED_DYNAMIC_EN.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        upd_valid_e2;
  logic [31:0] upd_pc_e2;
  logic        upd_taken_e2;
  logic [31:0] upd_target_e2;
  logic        upd_is_jump_e2;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string       name;
    logic        r;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uj;
    logic        et;
    logic [31:0] ep;
  } vec_t;
  typedef struct {
    string       name;
    logic        et;
    logic [31:0] ep;
  } exp_t;
  exp_t exp_q[$];
  vec_t vecs[25];
  branch_predictor dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_pc_f(pred_pc_f),
    .upd_valid_e2(upd_valid_e2), .upd_pc_e2(upd_pc_e2), .upd_taken_e2(upd_taken_e2),
    .upd_target_e2(upd_target_e2), .upd_is_jump_e2(upd_is_jump_e2)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(string n, logic r, logic [31:0] pc, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic uj, logic et, logic [31:0] ep);
    vec_t v;
    v.name = n; v.r = r; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utgt = utgt; v.uj = uj; v.et = et; v.ep = ep;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.r; pc_f = v.pc; upd_valid_e2 = v.uv; upd_pc_e2 = v.upc;
    upd_taken_e2 = v.ut; upd_target_e2 = v.utgt; upd_is_jump_e2 = v.uj;
    e.name = v.name;
`ifdef BRANCH_PRED_DYNAMIC_EN
    e.et = v.et; e.ep = v.ep;
`else
    e.et = 1'b0; e.ep = v.pc + 32'd4;
`endif
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    tests++;
    if (pred_taken_f !== e.et || pred_pc_f !== e.ep) begin
      fails++;
      $display("FAIL %s: got taken=%b pc=%h, want taken=%b pc=%h", e.name, pred_taken_f, pred_pc_f, e.et, e.ep);
    end
  endtask
  initial begin
    vecs[0]  = mk("reset_miss",      0, 32'h100, 0, 0,       0, 0,       0, 0, 32'h104);
    vecs[1]  = mk("same_cycle_old",  0, 32'h100, 1, 32'h100, 1, 32'h80,  0, 0, 32'h104);
    vecs[2]  = mk("alloc_weak_t",    0, 32'h100, 1, 32'h100, 1, 32'h80,  0, 1, 32'h80);
    vecs[3]  = mk("ctr_sat_hi_a",    0, 32'h100, 1, 32'h100, 1, 32'h80,  0, 1, 32'h80);
    vecs[4]  = mk("ctr_sat_hi_b",    0, 32'h100, 1, 32'h100, 1, 32'h80,  0, 1, 32'h80);
    vecs[5]  = mk("ctr_11_nt",       0, 32'h100, 1, 32'h100, 0, 0,       0, 1, 32'h80);
    vecs[6]  = mk("ctr_10_nt",       0, 32'h100, 1, 32'h100, 0, 0,       0, 1, 32'h80);
    vecs[7]  = mk("ctr_01",          0, 32'h100, 1, 32'h100, 0, 0,       0, 0, 32'h104);
    vecs[8]  = mk("ctr_00",          0, 32'h100, 1, 32'h100, 0, 0,       0, 0, 32'h104);
    vecs[9]  = mk("ctr_sat_lo",      0, 32'h100, 1, 32'h100, 1, 32'h80,  0, 0, 32'h104);
    vecs[10] = mk("ctr_01_again",    0, 32'h100, 1, 32'h100, 1, 32'h80,  0, 0, 32'h104);
    vecs[11] = mk("ctr_10_again",    0, 32'h100, 0, 0,       0, 0,       0, 1, 32'h80);
    vecs[12] = mk("alias_miss",      0, 32'h200, 1, 32'h200, 1, 32'h40,  0, 0, 32'h204);
    vecs[13] = mk("alias_hit",       0, 32'h200, 0, 0,       0, 0,       0, 1, 32'h40);
    vecs[14] = mk("alias_evicted",   0, 32'h100, 1, 32'h300, 0, 0,       0, 0, 32'h104);
    vecs[15] = mk("nt_no_alloc_a",   0, 32'h200, 0, 0,       0, 0,       0, 1, 32'h40);
    vecs[16] = mk("nt_no_alloc_b",   0, 32'h300, 0, 0,       0, 0,       0, 0, 32'h304);
    vecs[17] = mk("jump_alloc",      0, 32'h10,  1, 32'h10,  1, 32'h500, 1, 0, 32'h14);
    vecs[18] = mk("jump_nt_1",       0, 32'h10,  1, 32'h10,  0, 0,       1, 1, 32'h500);
    vecs[19] = mk("jump_nt_2",       0, 32'h10,  1, 32'h10,  0, 0,       1, 1, 32'h500);
    vecs[20] = mk("jump_nt_3",       0, 32'h10,  1, 32'h10,  0, 0,       0, 1, 32'h500);
    vecs[21] = mk("jump_cleared",    0, 32'h10,  0, 0,       0, 0,       0, 0, 32'h14);
    vecs[22] = mk("pc_wrap",         0, 32'hFFFFFFFC, 0, 0,  0, 0,       0, 0, 32'h0);
    vecs[23] = mk("hit_other_idx",   0, 32'h200, 0, 0,       0, 0,       0, 1, 32'h40);
    vecs[24] = mk("unrelated_miss",  0, 32'h1234, 0, 0,      0, 0,       0, 0, 32'h1238);
    rst = 1'b1; pc_f = 0; upd_valid_e2 = 0; upd_pc_e2 = 0;
    upd_taken_e2 = 0; upd_target_e2 = 0; upd_is_jump_e2 = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 25; i++) apply(vecs[i]);
    // reset coincident with an update: the update is dropped and all history is gone
    apply(mk("rst_with_upd",  1, 32'h500, 1, 32'h400, 1, 32'h60, 0, 1'bx, 32'hx));
    tests--;
    apply(mk("rst_upd_drop",  0, 32'h400, 0, 0, 0, 0, 0, 0, 32'h404));
    apply(mk("rst_hist_gone", 0, 32'h200, 0, 0, 0, 0, 0, 0, 32'h204));
    apply(mk("rst_jump_gone", 0, 32'h10,  0, 0, 0, 0, 0, 0, 32'h14));
    apply(mk("post_rst_alloc", 0, 32'h400, 1, 32'h400, 1, 32'h60, 0, 0, 32'h404));
    apply(mk("post_rst_hit",   0, 32'h400, 0, 0, 0, 0, 0, 1, 32'h60));
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
